// File: rtl/rbm_pkg.sv
// Shared types and constants for the RBM hidden-layer scheduler.
// Holds the FSM state enum, the Q0.16 probability type and LFSR constants.
package rbm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_KICK  = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_WB    = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    // Q0.16 unsigned probability
    typedef logic [15:0] prob_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rbm_lfsr16.sv
// 16-bit Fibonacci LFSR used as the uniform source for hidden sampling.
// Ports: clk, rst_n (sync, active-low), step_i (advance), value_o (state).
// Only present when RBM_SCHED_SAMPLE_EN is defined.
`ifdef RBM_SCHED_SAMPLE_EN
module rbm_lfsr16
    import rbm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  step_i,
    output prob_t value_o
);

    prob_t lfsr_q;
    prob_t lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/rbm_hidden_sched.sv
// Sequences rbm_core_min over hidden units 0..h_count-1 and writes each
// probability to a result buffer. Optional macro: RBM_SCHED_SAMPLE_EN adds
// an LFSR-driven Bernoulli sample in out_data[16].
// Ports: clk, rst_n (sync, active-low); start/abort/h_count control;
// busy/done/err status; col_sel weight/bias select; core_start/core_busy/
// core_p_j core handshake; out_we/out_addr/out_data result-buffer write.
module rbm_hidden_sched
    import rbm_pkg::*;
#(
    parameter int I_DIM   = 256,
    parameter int H_DIM   = 64,
    parameter int ARM_TMO = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(H_DIM+1)-1:0] h_count,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(H_DIM)-1:0]   col_sel,
    output logic                       core_start,
    input  logic                       core_busy,
    input  prob_t                      core_p_j,
    output logic                       out_we,
    output logic [$clog2(H_DIM)-1:0]   out_addr,
    output logic [16:0]                out_data
);

    localparam int HC_W  = $clog2(H_DIM + 1);
    localparam int IDX_W = $clog2(H_DIM);
    localparam int TMO_W = $clog2(ARM_TMO + 1);

    // I_DIM only sizes the core owned by the parent; validate it here.
    if (I_DIM < 1 || H_DIM < 2 || ARM_TMO < 1) begin : g_bad_cfg
        $error("rbm_hidden_sched: invalid parameters");
    end

    state_e             state_q, state_d;
    logic [HC_W-1:0]    hc_q, hc_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;

    logic [HC_W-1:0]    h_clamped;
    logic               last_unit;
    logic               live;
    logic               wr_fire;
    logic               sample_bit;

    assign h_clamped = (h_count > HC_W'(H_DIM)) ? HC_W'(H_DIM) : h_count;
    assign last_unit = (HC_W'(j_q) + HC_W'(1)) == hc_q;

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        j_d     = j_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hc_d    = h_clamped;
                        err_d   = 1'b0;
                        j_d     = '0;
                        state_d = (h_clamped == '0) ? ST_FIN : ST_SETUP;
                    end
                end
                ST_SETUP: state_d = ST_KICK;
                ST_KICK: begin
                    tmo_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (core_busy) begin
                        state_d = ST_RUN;
                    end else if (tmo_q == TMO_W'(ARM_TMO - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!core_busy) begin
                        state_d = ST_WB;
                    end
                end
                ST_WB: begin
                    if (last_unit) begin
                        state_d = ST_FIN;
                    end else begin
                        j_d     = j_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            j_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            j_q     <= j_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Strobes are suppressed in a cycle that is being aborted or reset,
    // so the edge that leaves the state never sees a partial action.
    assign live    = rst_n && !abort;
    assign wr_fire = (state_q == ST_WB) && live;

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN) && live;
    assign core_start = (state_q == ST_KICK) && live;
    assign err        = err_q;
    assign col_sel    = j_q;
    assign out_we     = wr_fire;
    assign out_addr   = j_q;
    assign out_data   = wr_fire ? {sample_bit, core_p_j} : '0;

`ifdef RBM_SCHED_SAMPLE_EN
    prob_t lfsr_val;

    rbm_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (wr_fire),
        .value_o (lfsr_val)
    );

    assign sample_bit = (core_p_j > lfsr_val);
`else
    assign sample_bit = 1'b0;
`endif

endmodule
